// File: rtl/multiword_add_sequencer.sv
// Multi-precision add sequencer: WORDS x 32-bit add, one word per cycle, LSW first.
// Define MWADD_SUB_EN to add the op_sub port and A-B support.

module rippleCarryAdder32 (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        Cout,
  output logic        overFlow
);
  logic [32:0] c;

  always_comb begin
    c    = '0;
    S    = '0;
    c[0] = Cin;
    for (int unsigned i = 0; i < 32; i++) begin
      S[i]   = A[i] ^ B[i] ^ c[i];
      c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    Cout     = c[32];
    overFlow = c[32] ^ c[31];
  end
endmodule

module multiword_add_sequencer #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [32*WORDS-1:0]   a_in,
  input  logic [32*WORDS-1:0]   b_in,
  input  logic                  cin,
`ifdef MWADD_SUB_EN
  input  logic                  op_sub,
`endif
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [32*WORDS-1:0]   sum_out,
  output logic                  cout,
  output logic                  overflow,
  output logic                  busy
);
  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q;
  logic [IW-1:0]          idx_q;
  logic [WORDS-1:0][31:0] a_q, b_q, sum_q;
  logic                   cin_q, carry_q;
  logic                   cout_q, ovf_q, res_valid_q, start_ready_q, busy_q;
  logic [31:0]            add_a, add_b, add_s;
  logic                   add_cin, add_co, add_ov;
`ifdef MWADD_SUB_EN
  logic                   sub_q;
`endif

  always_comb begin
    add_a   = a_q[idx_q];
`ifdef MWADD_SUB_EN
    add_b   = b_q[idx_q] ^ {32{sub_q}};
`else
    add_b   = b_q[idx_q];
`endif
    add_cin = (idx_q == '0) ? cin_q : carry_q;
  end

  rippleCarryAdder32 u_adder (
    .A        (add_a),
    .B        (add_b),
    .Cin      (add_cin),
    .S        (add_s),
    .Cout     (add_co),
    .overFlow (add_ov)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      sum_q         <= '0;
      cin_q         <= 1'b0;
      carry_q       <= 1'b0;
      cout_q        <= 1'b0;
      ovf_q         <= 1'b0;
      res_valid_q   <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
`ifdef MWADD_SUB_EN
      sub_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q           <= a_in;
            b_q           <= b_in;
            idx_q         <= '0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= RUN;
`ifdef MWADD_SUB_EN
            // Subtract: word-0 carry-in of 1 completes the two's complement of B.
            sub_q         <= op_sub;
            cin_q         <= op_sub | cin;
`else
            cin_q         <= cin;
`endif
          end
        end
        RUN: begin
          sum_q[idx_q] <= add_s;
          carry_q      <= add_co;
          if (idx_q == LAST) begin
            cout_q      <= add_co;
            ovf_q       <= add_ov;
            res_valid_q <= 1'b1;
            idx_q       <= '0;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign sum_out     = sum_q;
  assign cout        = cout_q;
  assign overflow    = ovf_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer (WORDS=4): vector table,
// scoreboard queue, plus backpressure and mid-operation reset sequences.
module tb_multiword_add_sequencer;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W = 32 * WORDS;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic         op_sub = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] sum_out;
  logic         cout;
  logic         overflow;
  logic         busy;

  int n_pass = 0;
  int n_total = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .cin         (cin),
`ifdef MWADD_SUB_EN
    .op_sub      (op_sub),
`endif
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum_out     (sum_out),
    .cout        (cout),
    .overflow    (overflow),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sub);
    exp_t e;
    logic [W:0] full;
    logic [W-1:0] bb;
    logic c0;
    bb = sub ? ~b : b;
    c0 = sub ? 1'b1 : ci;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
    e.s  = full[W-1:0];
    e.co = full[W];
    e.ov = (a[W-1] == bb[W-1]) && (e.s[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic sub, input exp_t e);
    @(negedge clk);
    chk("start_ready_idle", W'(start_ready), W'(1));
    a_in = a; b_in = b; cin = ci; op_sub = sub; start_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a_in = ~a; b_in = ~b; cin = ~ci; op_sub = ~sub;
  endtask

  task automatic wait_result(input string name);
    int n;
    exp_t e;
    n = 0;
    while (n < 3 * WORDS + 10) begin
      @(posedge clk);
      #1;
      n++;
      if (res_valid) break;
    end
    if (!res_valid) begin
      n_total++;
      $display("FAIL %s_timeout: res_valid never rose within %0d cycles", name, n);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    chk({name, "_latency"}, W'(n), W'(WORDS));
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL %s_scoreboard: result with empty queue", name);
      return;
    end
    e = sb.pop_front();
    chk({name, "_sum"}, sum_out, e.s);
    chk({name, "_cout"}, W'(cout), W'(e.co));
    chk({name, "_ovf"}, W'(overflow), W'(e.ov));
  endtask

  task automatic run_vec(input vec_t v, input string name);
    exp_t e;
    e.s = v.s; e.co = v.co; e.ov = v.ov;
    issue(v.a, v.b, v.ci, v.sub, e);
    wait_result(name);
    @(posedge clk);
    #1;
    chk({name, "_res_valid_drop"}, W'(res_valid), W'(0));
  endtask

  task automatic add_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sub, input logic [W-1:0] s, input logic co, input logic ov);
    vec_t v;
    v.a = a; v.b = b; v.ci = ci; v.sub = sub; v.s = s; v.co = co; v.ov = ov;
    vecs.push_back(v);
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb, held;
    vec_t rv;

    add_vec({32'h7FFFFFFF, {3{32'hFFFFFFFF}}}, W'(1), 1'b0, 1'b0,
            {32'h80000000, {3{32'h0}}}, 1'b0, 1'b1);
    add_vec({4{32'hFFFFFFFF}}, W'(1), 1'b0, 1'b0, '0, 1'b1, 1'b0);
    add_vec(W'(32'hFFFFFFFF), W'(1), 1'b1, 1'b0, {64'h0, 32'h1, 32'h1}, 1'b0, 1'b0);
    add_vec(W'(5), W'(5), 1'b0, 1'b0, W'(10), 1'b0, 1'b0);
    add_vec({32'h80000000, {3{32'h0}}}, {32'h80000000, {3{32'h0}}}, 1'b0, 1'b0,
            '0, 1'b1, 1'b1);
    add_vec('0, '0, 1'b1, 1'b0, W'(1), 1'b0, 1'b0);
    add_vec({32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF},
            {32'h00000002, 32'h00000000, 32'hFFFFFFFF, 32'h00000001}, 1'b0, 1'b0,
            {32'h00000004, 32'h00000000, 32'h00000000, 32'h00000000}, 1'b0, 1'b0);
`ifdef MWADD_SUB_EN
    add_vec(W'(5), W'(5), 1'b0, 1'b1, '0, 1'b1, 1'b0);
    add_vec({32'h80000000, {3{32'h0}}}, W'(1), 1'b0, 1'b1,
            {32'h7FFFFFFF, {3{32'hFFFFFFFF}}}, 1'b1, 1'b1);
`endif

    #12;
    chk("rst_start_ready", W'(start_ready), W'(1));
    chk("rst_res_valid", W'(res_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_sum", sum_out, '0);
    chk("rst_cout_ovf", W'({cout, overflow}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 4; i++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rv.a = ra; rv.b = rb; rv.ci = i[0]; rv.sub = 1'b0;
`ifdef MWADD_SUB_EN
      rv.sub = i[1];
`endif
      e = model(ra, rb, rv.ci, rv.sub);
      rv.s = e.s; rv.co = e.co; rv.ov = e.ov;
      run_vec(rv, $sformatf("rand%0d", i));
    end

    // Backpressure: result must hold and new requests must be ignored.
    res_ready = 1'b0;
    e = model(W'(3), W'(4), 1'b0, 1'b0);
    issue(W'(3), W'(4), 1'b0, 1'b0, e);
    wait_result("bp");
    held = sum_out;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start_valid = 1'b1;
      a_in = W'(100 + i); b_in = W'(i);
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold_valid%0d", i), W'(res_valid), W'(1));
      chk($sformatf("bp_hold_sum%0d", i), sum_out, W'(7));
      chk($sformatf("bp_hold_flags%0d", i), W'({cout, overflow}), W'(0));
      chk($sformatf("bp_start_ready%0d", i), W'(start_ready), W'(0));
    end
    @(negedge clk);
    start_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", W'(res_valid), W'(0));
    chk("bp_release_ready", W'(start_ready), W'(1));
    chk("bp_release_busy", W'(busy), W'(0));
    chk("bp_sum_unchanged", sum_out, held);

    // Reset two cycles into RUN discards the operation.
    e = model({4{32'hFFFFFFFF}}, W'(1), 1'b0, 1'b0);
    issue({4{32'hFFFFFFFF}}, W'(1), 1'b0, 1'b0, e);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", sum_out, '0);
    chk("mid_rst_valid", W'(res_valid), W'(0));
    chk("mid_rst_busy", W'(busy), W'(0));
    chk("mid_rst_flags", W'({cout, overflow}), W'(0));
    chk("mid_rst_ready", W'(start_ready), W'(1));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    e = model(W'(5), W'(5), 1'b0, 1'b0);
    issue(W'(5), W'(5), 1'b0, 1'b0, e);
    wait_result("post_rst");
    @(posedge clk);
    #1;
    chk("post_rst_idle", W'(start_ready), W'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
- Multi-precision add sequencer: performs a WORDS×32-bit two's-complement add by running the shared 32-bit ripple-carry adder core (rippleCarryAdder32) once per cycle, chaining carry word-to-word, least significant word first.
- Operation interface is valid/ready on both sides; one operation in flight.
- Reports the full sum, the final carry-out and signed overflow of the full-width result.

Parameters:
- WORDS, 4, number of 32-bit words per operand; legal range 1..16; operand width W = 32*WORDS.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  operation request.
- start_ready  output  1  sequencer can accept a request.
- a_in  input  W  operand A.
- b_in  input  W  operand B.
- cin  input  1  carry-in applied to word 0.
- op_sub  input  1  subtract select; present only with MWADD_SUB_EN.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- sum_out  output  W  result.
- cout  output  1  carry-out of the most significant word.
- overflow  output  1  signed overflow of the W-bit result.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, idx=0, operand and carry registers=0, sum_out=0, cout=0, overflow=0, res_valid=0, busy=0, start_ready=1.
- Reset asserted mid-RUN or in DONE discards the operation; no partial result is ever flagged valid.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid=1 at a clock edge: latch a_in, b_in and cin; idx=0; go to RUN.
- RUN:
  - start_ready=0.
  - Each cycle the adder gets A=a_reg[idx], B=b_reg[idx], Cin = latched cin when idx=0, otherwise the carry register.
  - At the clock edge: S is written to sum_out word idx, Cout is written to the carry register, idx increments.
  - When the edge completes idx=WORDS-1: cout=Cout, overflow=overFlow from that last word, go to DONE.
- DONE:
  - res_valid=1; sum_out, cout and overflow are held stable.
  - On res_valid & res_ready at an edge: res_valid=0, go to IDLE.
  - A new request cannot be accepted in the same edge as the result handshake.
- Latency:
  - res_valid rises exactly WORDS cycles after the acceptance edge.
  - Minimum issue interval is WORDS+2 cycles with res_ready held high.
- Input changes on a_in, b_in, cin or op_sub after acceptance are ignored.
- start_valid is ignored outside IDLE.
- Upper sum_out words are unspecified until DONE; consumers sample only when res_valid=1.
- WORDS=1: RUN lasts a single cycle; word 0 is also the last word.
- overflow uses signed semantics of the full W-bit operands: it is the sign-overflow of the MSW only. Carry-out and overflow are independent.

Optional Feature:
- MWADD_SUB_EN defined:
  - op_sub port exists and is latched at acceptance.
  - When op_sub=1: each B word is inverted before the adder, and word 0 carry-in is forced to 1 (cin ignored), computing A−B.
  - cout is then the no-borrow flag; overflow is signed subtraction overflow.
- MWADD_SUB_EN undefined:
  - No op_sub port; addition only; no inverter logic is instantiated.

Test Plan:
- WORDS=4, a=0x7FFF…FFFF, b=1, cin=0 -> sum=0x8000…0000, cout=0, overflow=1; res_valid exactly 4 cycles after acceptance.
- a=0xFFFF…FFFF, b=1 -> sum=0, cout=1, overflow=0; carry ripples through all four words.
- a=0x0…0_FFFFFFFF, b=0x0…0_00000001, cin=1 -> sum=0x0…1_00000001, cout=0, overflow=0; checks word-boundary carry plus cin.
- Backpressure: hold res_ready=0 for 5 cycles in DONE -> res_valid, sum_out, cout and overflow are stable, start_ready=0, and start_valid pulses are ignored. Raise res_ready -> IDLE next edge, start_ready=1.
- Reset mid-op: assert rst_n=0 two cycles into RUN -> all outputs 0 immediately (asynchronously). After release, start_ready=1, and a new op a=5, b=5 yields sum=10 with no residue from the aborted op.
- MWADD_SUB_EN: a=5, b=5, op_sub=1 -> sum=0, cout=1, overflow=0. a=0x8000…0, b=1, op_sub=1 -> sum=0x7FFF…FFFF, overflow=1.
